// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uc_pkg
//  Description : Shared types and constants for the unidad_control block:
//                opcode enum, FSM state enum, control-word field positions
//                and flag bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package uc_pkg;

  // Instruction opcodes, instr[7:4]
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LOAD = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_OUT  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_ADR  = 4'hC,
    OP_NOPD = 4'hD,
    OP_NOPE = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Control word field positions
  localparam int ALU_OP_LSB   = 12;  // [15:12]
  localparam int SEL_A_LSB    = 10;  // [11:10]
  localparam int SEL_B_LSB    = 8;   // [9:8]
  localparam int DEST_LSB     = 6;   // [7:6]
  localparam int REG_WE_BIT   = 5;
  localparam int LOAD_IN_BIT  = 4;
  localparam int OUT_WE_BIT   = 3;
  localparam int FLAGS_WE_BIT = 2;
  localparam int ADR_WE_BIT   = 1;

  // Datapath flag positions
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

endpackage
`default_nettype wire

// File: rtl/decodificador_control.sv
`default_nettype none
// ============================================================================
//  Module      : decodificador_control
//  Description : Combinational instruction decoder. Maps the instruction
//                register and the datapath flags to the 16-bit control word
//                and the jump-taken decision.
//  Ports       : ir      - instruction register (opcode [7:4], operand [3:0])
//                flags   - datapath flags {V,N,C,Z}
//                control - decoded control word
//                jump    - 1 when the instruction loads pc with imm4
//  Revision    : 1.0 - initial release
// ============================================================================
module decodificador_control
  import uc_pkg::*;
(
  input  logic [7:0]  ir,
  input  logic [3:0]  flags,
  output logic [15:0] control,
  output logic        jump
);

  opcode_t    op;
  logic [1:0] rd;
  logic [1:0] rs;

  assign op = opcode_t'(ir[7:4]);
  assign rd = ir[3:2];
  assign rs = ir[1:0];

  // N and V are not consumed by any jump condition
  logic unused_flags;
  assign unused_flags = ^flags[3:2];

  always_comb begin
    control = '0;
    jump    = 1'b0;
    case (op)
      OP_LOAD: begin
        control[REG_WE_BIT]  = 1'b1;
        control[LOAD_IN_BIT] = 1'b1;
      end
      // MOV routes rs through the ALU but leaves the flags untouched
      OP_MOV: begin
        control[ALU_OP_LSB +: 4] = ir[7:4];
        control[SEL_A_LSB  +: 2] = rd;
        control[SEL_B_LSB  +: 2] = rs;
        control[DEST_LSB   +: 2] = rd;
        control[REG_WE_BIT]      = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        control[ALU_OP_LSB +: 4] = ir[7:4];
        control[SEL_A_LSB  +: 2] = rd;
        control[SEL_B_LSB  +: 2] = rs;
        control[DEST_LSB   +: 2] = rd;
        control[REG_WE_BIT]      = 1'b1;
        control[FLAGS_WE_BIT]    = 1'b1;
      end
      OP_OUT:  control[OUT_WE_BIT] = 1'b1;
      OP_ADR:  control[ADR_WE_BIT] = 1'b1;
      // Jumps act on pc only; their control word stays zero
      OP_JMP:  jump = 1'b1;
      OP_JZ:   jump = flags[FLAG_Z];
      OP_JC:   jump = flags[FLAG_C];
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/unidad_control.sv
`default_nettype none
// ============================================================================
//  Module      : unidad_control
//  Description : Three-cycle FETCH/DECODE/EXEC control unit with IDLE and
//                HALT states. Drives the program address, and asserts the
//                registered control word for exactly one EXEC cycle.
//  Ports       : clk      - system clock, rising edge
//                rst      - asynchronous active-high reset
//                run      - start request, honoured in IDLE and HALT only
//                instr_in - instruction at pc_out
//                flags    - datapath flags {V,N,C,Z}, sampled in EXEC
//                pc_out   - program memory address
//                control  - datapath control word (non-zero only in EXEC)
//                busy     - FETCH, DECODE or EXEC
//                halted   - HALT
//  Revision    : 1.0 - initial release
// ============================================================================
module unidad_control
  import uc_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [7:0]      instr_in,
  input  logic [3:0]      flags,
  output logic [PC_W-1:0] pc_out,
  output logic [15:0]     control,
  output logic            busy,
  output logic            halted
);

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic [15:0]     ctrl_q;
  logic [15:0]     dec_control;
  logic            jump;
  logic [PC_W-1:0] jump_target;

  decodificador_control u_dec (
    .ir      (ir),
    .flags   (flags),
    .control (dec_control),
    .jump    (jump)
  );

  assign jump_target = PC_W'(ir[3:0]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (run) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = (ir[7:4] == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:   if (run) state_next = ST_FETCH;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Program counter, instruction register and registered control word.
  // A taken jump in EXEC replaces the value incremented in FETCH, so the
  // target also wins over the 15->0 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      ir     <= '0;
      ctrl_q <= '0;
    end else begin
      case (state)
        ST_IDLE:   pc <= '0;
        ST_FETCH: begin
          ir <= instr_in;
          pc <= pc + PC_W'(1);
        end
        ST_DECODE: ctrl_q <= dec_control;
        ST_EXEC:   if (jump) pc <= jump_target;
        ST_HALT:   if (run) pc <= '0;
        default:   ;
      endcase
    end
  end

  // Gating on state (not on ctrl_q) keeps control at zero outside EXEC and
  // makes reset clear it in the same cycle.
  assign control = (state == ST_EXEC) ? ctrl_q : 16'h0000;
  assign pc_out  = pc;
  assign busy    = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
  assign halted  = (state == ST_HALT);

endmodule
`default_nettype wire
